// File: rtl/sr_sched_pkg.sv
// Shared opcode and state encodings for the SR flip-flop command scheduler.
package sr_sched_pkg;

   localparam logic [1:0] OP_READ = 2'b00;
   localparam logic [1:0] OP_SET  = 2'b01;
   localparam logic [1:0] OP_CLR  = 2'b10;
   localparam logic [1:0] OP_TOG  = 2'b11;

   localparam logic [1:0] ST_IDLE   = 2'b00;
   localparam logic [1:0] ST_DRIVE  = 2'b01;
   localparam logic [1:0] ST_SETTLE = 2'b10;
   localparam logic [1:0] ST_DONE   = 2'b11;

   // Requester-id width; a single requester still needs one bit.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sr_ff_cmd_scheduler_arb.sv
// Combinational round-robin pick: first asserted req at or above ptr, with wrap.
module sr_rr_arbiter
   import sr_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [IDW-1:0]  gnt_id,
   output logic            gnt_valid
);

   always_comb begin
      int k;
      k         = 0;
      gnt_id    = '0;
      gnt_valid = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         k = int'(ptr) + i;
         if (k >= NREQ) k = k - NREQ;
         if (!gnt_valid && req[k]) begin
            gnt_valid = 1'b1;
            gnt_id    = IDW'(k);
         end
      end
   end

endmodule

// File: rtl/sr_ff_cmd_scheduler.sv
// Time-shares one bank of SR flip-flops between NREQ requesters, one S or R pulse per command.
// Define SR_SCHED_TOGGLE_EN to enable opcode 11 as TOGGLE; otherwise it is rejected.
//
// state     | meaning
// ST_IDLE   | arbitrate; on a grant latch the command and precompute the S/R pulse
// ST_DRIVE  | exactly one S or R bit high (none for READ or rejected commands)
// ST_SETTLE | S/R low, bank output settles; Q_in[idx] captured into rd_data
// ST_DONE   | ack (and err if rejected) to the winner; round-robin pointer advances
module sr_ff_cmd_scheduler
   import sr_sched_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int IDXW  = 3
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [NREQ-1:0]      req,
   input  logic [2*NREQ-1:0]    op,
   input  logic [IDXW*NREQ-1:0] idx,
   output logic [NREQ-1:0]      ack,
   output logic                 err,
   output logic                 rd_data,
   output logic                 busy,
   output logic [WIDTH-1:0]     S,
   output logic [WIDTH-1:0]     R,
   input  logic [WIDTH-1:0]     Q_in
);

   localparam int IDW = id_width(NREQ);

`ifdef SR_SCHED_TOGGLE_EN
   localparam bit TOG_EN = 1'b1;
`else
   localparam bit TOG_EN = 1'b0;
`endif

   logic [1:0]       state_q, state_d;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]   win_id_q, win_id_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic             rej_q, rej_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [NREQ-1:0]  ack_q, ack_d;
   logic             err_q, err_d;
   logic             rd_data_q, rd_data_d;

   logic [IDW-1:0]   gnt_id;
   logic             gnt_valid;
   logic [1:0]       w_op;
   logic [IDXW-1:0]  w_idx;
   logic             w_in_range;
   logic             w_q;
   logic             w_rej;
   logic [WIDTH-1:0] w_bit;

   sr_rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .req       (req),
      .ptr       (rr_ptr_q),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid)
   );

   // S/R are registered so the bank only ever sees clean single-cycle pulses.
   always_comb begin
      w_op       = op[2*gnt_id +: 2];
      w_idx      = idx[IDXW*gnt_id +: IDXW];
      w_in_range = (int'(w_idx) < WIDTH);
      w_q        = w_in_range ? Q_in[w_idx] : 1'b0;
      w_rej      = !w_in_range || ((w_op == OP_TOG) && !TOG_EN);
      w_bit      = WIDTH'(1) << w_idx;
   end

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      win_id_d  = win_id_q;
      idx_d     = idx_q;
      rej_d     = rej_q;
      s_d       = '0;
      r_d       = '0;
      ack_d     = '0;
      err_d     = 1'b0;
      rd_data_d = rd_data_q;
      case (state_q)
         ST_IDLE: begin
            if (gnt_valid) begin
               state_d  = ST_DRIVE;
               win_id_d = gnt_id;
               idx_d    = w_idx;
               rej_d    = w_rej;
               if (!w_rej) begin
                  case (w_op)
                     OP_SET:  s_d = w_bit;
                     OP_CLR:  r_d = w_bit;
                     OP_TOG: begin
                        if (w_q) r_d = w_bit;
                        else     s_d = w_bit;
                     end
                     default: ;
                  endcase
               end
            end
         end
         ST_DRIVE: state_d = ST_SETTLE;
         ST_SETTLE: begin
            state_d   = ST_DONE;
            rd_data_d = (int'(idx_q) < WIDTH) ? Q_in[idx_q] : 1'b0;
            ack_d     = NREQ'(1) << win_id_q;
            err_d     = rej_q;
         end
         default: begin
            state_d  = ST_IDLE;
            rr_ptr_d = (win_id_q == IDW'(NREQ - 1)) ? '0 : win_id_q + 1'b1;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= ST_IDLE;
         rr_ptr_q  <= '0;
         win_id_q  <= '0;
         idx_q     <= '0;
         rej_q     <= 1'b0;
         s_q       <= '0;
         r_q       <= '0;
         ack_q     <= '0;
         err_q     <= 1'b0;
         rd_data_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         win_id_q  <= win_id_d;
         idx_q     <= idx_d;
         rej_q     <= rej_d;
         s_q       <= s_d;
         r_q       <= r_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign S       = s_q;
   assign R       = r_q;
   assign ack     = ack_q;
   assign err     = err_q;
   assign rd_data = rd_data_q;
   assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sr_ff_cmd_scheduler.sv
// Scoreboard bench for sr_ff_cmd_scheduler; expectations follow SR_SCHED_TOGGLE_EN when defined.
module tb_sr_ff_cmd_scheduler;

   localparam logic [1:0] C_READ = 2'b00;
   localparam logic [1:0] C_SET  = 2'b01;
   localparam logic [1:0] C_CLR  = 2'b10;
   localparam logic [1:0] C_TOG  = 2'b11;

   logic        CLK;
   logic        RST;
   logic [3:0]  req;
   logic [7:0]  op;
   logic [11:0] idx;
   logic [3:0]  ack;
   logic        err;
   logic        rd_data;
   logic        busy;
   logic [7:0]  S;
   logic [7:0]  R;
   logic [7:0]  Q_in;

   logic [3:0]  req2;
   logic [7:0]  op2;
   logic [11:0] idx2;
   logic [3:0]  ack2;
   logic        err2;
   logic        rd2;
   logic        busy2;
   logic [5:0]  S2;
   logic [5:0]  R2;
   logic [5:0]  Q2;

   sr_ff_cmd_scheduler #(.NREQ(4), .WIDTH(8), .IDXW(3)) dut (
      .CLK(CLK), .RST(RST), .req(req), .op(op), .idx(idx), .ack(ack), .err(err),
      .rd_data(rd_data), .busy(busy), .S(S), .R(R), .Q_in(Q_in)
   );

   sr_ff_cmd_scheduler #(.NREQ(4), .WIDTH(6), .IDXW(3)) dut_w6 (
      .CLK(CLK), .RST(RST), .req(req2), .op(op2), .idx(idx2), .ack(ack2), .err(err2),
      .rd_data(rd2), .busy(busy2), .S(S2), .R(R2), .Q_in(Q2)
   );

   typedef struct {
      int         id;
      bit         err;
      bit         rd;
      logic [7:0] s;
      logic [7:0] r;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   start_cyc = -100;
   int   acks_seen = 0;
   bit   busy_prev = 1'b0;
   logic [7:0] obs_s = '0;
   logic [7:0] obs_r = '0;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog");
   end

   // Monitor: per-cycle SR invariants plus scoreboard pop on every ack.
   always @(negedge CLK) begin
      exp_t e;
      cyc++;
      if (!RST) begin
         if (busy && !busy_prev) begin
            start_cyc = cyc;
            obs_s     = S;
            obs_r     = R;
         end
         checks++;
         if (((S & R) != 0) || ($countones(S | R) > 1) ||
             (((S | R) != 0) && !(busy && cyc == start_cyc)) || (err && ack == 0)) begin
            errors++;
            $display("FAIL sr_invariant: S=%h R=%h busy=%b err=%b ack=%b cyc=%0d", S, R, busy, err, ack, cyc);
         end
         if (ack != 0) begin
            acks_seen++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_ack: ack=%b, required none", ack);
            end else begin
               e = exp_q.pop_front();
               if (ack !== 4'(1 << e.id)) begin
                  errors++;
                  $display("FAIL ack_id: ack=%b, required %b", ack, 4'(1 << e.id));
               end
               checks++;
               if (err !== e.err) begin
                  errors++;
                  $display("FAIL err_flag: err=%b, required %b (id %0d)", err, e.err, e.id);
               end
               checks++;
               if (rd_data !== e.rd) begin
                  errors++;
                  $display("FAIL rd_data: rd_data=%b, required %b (id %0d)", rd_data, e.rd, e.id);
               end
               checks++;
               if (obs_s !== e.s || obs_r !== e.r) begin
                  errors++;
                  $display("FAIL drive: S=%h R=%h, required S=%h R=%h (id %0d)", obs_s, obs_r, e.s, e.r, e.id);
               end
               checks++;
               if (cyc - start_cyc !== 2) begin
                  errors++;
                  $display("FAIL latency: ack %0d cycles after DRIVE, required 2", cyc - start_cyc);
               end
            end
         end
      end
      busy_prev = busy;
   end

   task automatic push_exp(input int id, input bit e, input bit rd, input logic [7:0] s, input logic [7:0] r);
      exp_t x;
      x.id = id; x.err = e; x.rd = rd; x.s = s; x.r = r;
      exp_q.push_back(x);
   endtask

   task automatic set_cmd(input int i, input logic [1:0] o, input logic [2:0] x);
      op[2*i +: 2]  = o;
      idx[3*i +: 3] = x;
   endtask

   task automatic wait_acks(input int target, input int budget, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < budget && !ok; n++) begin
         @(negedge CLK);
         if (acks_seen >= target) ok = 1'b1;
      end
   endtask

   task automatic do_reset();
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic test_reset();
      bit ok;
      op = '0; idx = '0; Q_in = '0; req = 4'b1111; RST = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge CLK);
         checks++;
         if (ack !== 4'b0 || S !== 8'h00 || R !== 8'h00 || busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ack=%b S=%h R=%h busy=%b err=%b, required all 0", ack, S, R, busy, err);
         end
      end
      push_exp(0, 1'b0, 1'b0, 8'h00, 8'h00);
      RST = 1'b0;
      wait_acks(acks_seen + 1, 12, ok);
      req = 4'b0000;
      checks++;
      if (!ok) begin errors++; $display("FAIL reset_first_grant: no ack, required ack[0]"); end
      repeat (3) @(negedge CLK);
   endtask

   task automatic test_set();
      bit ok;
      Q_in = 8'h00;
      set_cmd(0, C_SET, 3'd3);
      push_exp(0, 1'b0, 1'b0, 8'h08, 8'h00);
      req = 4'b0001;
      wait_acks(acks_seen + 1, 12, ok);
      req = 4'b0000;
      checks++;
      if (!ok) begin errors++; $display("FAIL set_timeout: no ack, required ack[0]"); end
      repeat (3) @(negedge CLK);
   endtask

   task automatic test_round_robin();
      bit ok;
      do_reset();
      Q_in = 8'h00;
      for (int i = 0; i < 4; i++) set_cmd(i, C_CLR, 3'(i));
      for (int n = 0; n < 5; n++) push_exp(n % 4, 1'b0, 1'b0, 8'h00, 8'(1 << (n % 4)));
      req = 4'b1111;
      wait_acks(acks_seen + 5, 40, ok);
      req = 4'b0000;
      checks++;
      if (!ok) begin errors++; $display("FAIL rr_timeout: acks=%0d, required 5 more", acks_seen); end
      repeat (3) @(negedge CLK);
   endtask

   task automatic test_read();
      bit ok;
      Q_in = 8'h20;
      set_cmd(2, C_READ, 3'd5);
      push_exp(2, 1'b0, 1'b1, 8'h00, 8'h00);
      req = 4'b0100;
      wait_acks(acks_seen + 1, 12, ok);
      req = 4'b0000;
      checks++;
      if (!ok) begin errors++; $display("FAIL read_timeout: no ack, required ack[2]"); end
      repeat (2) @(negedge CLK);
      Q_in = 8'hDF;
      set_cmd(1, C_READ, 3'd5);
      push_exp(1, 1'b0, 1'b0, 8'h00, 8'h00);
      req = 4'b0010;
      wait_acks(acks_seen + 1, 12, ok);
      req = 4'b0000;
      checks++;
      if (!ok) begin errors++; $display("FAIL read0_timeout: no ack, required ack[1]"); end
      repeat (3) @(negedge CLK);
   endtask

   task automatic test_toggle();
      bit ok;
      logic [7:0] qv [2];
      qv[0] = 8'h10;
      qv[1] = 8'h00;
      for (int t = 0; t < 2; t++) begin
         Q_in = qv[t];
         set_cmd(3, C_TOG, 3'd4);
`ifdef SR_SCHED_TOGGLE_EN
         push_exp(3, 1'b0, Q_in[4], Q_in[4] ? 8'h00 : 8'h10, Q_in[4] ? 8'h10 : 8'h00);
`else
         push_exp(3, 1'b1, Q_in[4], 8'h00, 8'h00);
`endif
         req = 4'b1000;
         wait_acks(acks_seen + 1, 12, ok);
         req = 4'b0000;
         checks++;
         if (!ok) begin errors++; $display("FAIL toggle_timeout: no ack, required ack[3] (case %0d)", t); end
         repeat (3) @(negedge CLK);
      end
   endtask

   task automatic test_reject_width();
      logic [2:0] tidx [2];
      bit         terr [2];
      logic [5:0] tdrv [2];
      logic [5:0] drv;
      logic [3:0] got_ack;
      bit         got_err;
      tidx[0] = 3'd7; terr[0] = 1'b1; tdrv[0] = 6'h00;
      tidx[1] = 3'd5; terr[1] = 1'b0; tdrv[1] = 6'h20;
      Q2 = '0; op2 = '0; idx2 = '0;
      for (int t = 0; t < 2; t++) begin
         op2[3:2]  = C_SET;
         idx2[5:3] = tidx[t];
         req2      = 4'b0010;
         drv = '0; got_ack = '0; got_err = 1'b0;
         for (int n = 0; n < 10 && got_ack == 0; n++) begin
            @(negedge CLK);
            drv     = drv | S2 | R2;
            got_ack = ack2;
            got_err = err2;
         end
         req2 = 4'b0000;
         checks++;
         if (got_ack !== 4'b0010) begin
            errors++;
            $display("FAIL w6_ack: ack=%b, required 0010 (idx %0d)", got_ack, tidx[t]);
         end
         checks++;
         if (got_err !== terr[t]) begin
            errors++;
            $display("FAIL w6_err: err=%b, required %b (idx %0d)", got_err, terr[t], tidx[t]);
         end
         checks++;
         if (drv !== tdrv[t]) begin
            errors++;
            $display("FAIL w6_drive: S|R=%h, required %h (idx %0d)", drv, tdrv[t], tidx[t]);
         end
         repeat (3) @(negedge CLK);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      bit seen;
      Q_in = 8'h00;
      set_cmd(2, C_READ, 3'd0);
      push_exp(2, 1'b0, 1'b0, 8'h00, 8'h00);
      req = 4'b0100;
      wait_acks(acks_seen + 1, 12, ok);
      req = 4'b0000;
      checks++;
      if (!ok) begin errors++; $display("FAIL mid_setup_timeout: no ack, required ack[2]"); end
      repeat (3) @(negedge CLK);
      set_cmd(0, C_SET, 3'd2);
      req  = 4'b0001;
      seen = 1'b0;
      for (int n = 0; n < 10 && !seen; n++) begin
         @(negedge CLK);
         seen = busy;
      end
      checks++;
      if (!seen || S !== 8'h04) begin
         errors++;
         $display("FAIL mid_drive: busy=%b S=%h, required busy=1 S=04", busy, S);
      end
      RST = 1'b1;
      @(negedge CLK);
      checks++;
      if (S !== 8'h00 || R !== 8'h00 || busy !== 1'b0 || ack !== 4'b0) begin
         errors++;
         $display("FAIL mid_reset: S=%h R=%h busy=%b ack=%b, required all 0", S, R, busy, ack);
      end
      RST = 1'b0;
      req = 4'b0000;
      repeat (4) @(negedge CLK);
      set_cmd(1, C_READ, 3'd0);
      set_cmd(3, C_READ, 3'd0);
      push_exp(1, 1'b0, 1'b0, 8'h00, 8'h00);
      req = 4'b1010;
      wait_acks(acks_seen + 1, 12, ok);
      req = 4'b0000;
      checks++;
      if (!ok) begin errors++; $display("FAIL mid_restart_timeout: no ack, required ack[1]"); end
      repeat (3) @(negedge CLK);
   endtask

   initial begin
      RST = 1'b1; req = '0; op = '0; idx = '0; Q_in = '0;
      req2 = '0; op2 = '0; idx2 = '0; Q2 = '0;
      test_reset();
      test_set();
      test_round_robin();
      test_read();
      test_toggle();
      test_reject_width();
      test_reset_mid();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_expected: %0d acks outstanding, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
